// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and sizing for the BNN neuron-row parameter chain.
// Rev 1.0
`default_nettype none

package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_NEURONS   = 4;
   localparam int DEF_INPUTS    = 8;
   localparam int DEF_BIAS_BITS = 3;

   // Bits held by one row's daisy chain; also used to size neuron-row instances.
   function automatic int total_bits(input int neurons, input int inputs, input int bias_bits);
      return neurons * (inputs + bias_bits);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_piso8.sv
// bnn_piso8: 8-bit parallel-load / serial-out register, MSB first, with bit count.
// Rev 1.0
`default_nettype none

module bnn_piso8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] din,
   output logic       msb,
   output logic [3:0] count,
   output logic       empty
);

   logic [7:0] sr;

   // Load wins over shift so a byte can be refilled on its predecessor's last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= 8'd0;
         count <= 4'd0;
      end else if (load) begin
         sr    <= din;
         count <= 4'd8;
      end else if (shift && (count != 4'd0)) begin
         sr    <= {sr[6:0], 1'b0};
         count <= count - 4'd1;
      end
   end

   assign msb   = sr[7];
   assign empty = (count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: accepts parameter bytes and serialises them onto the neuron chain.
// Rev 1.0
`default_nettype none

module bnn_param_loader
   import bnn_pkg::*;
#(
   parameter int NEURONS   = DEF_NEURONS,
   parameter int INPUTS    = DEF_INPUTS,
   parameter int BIAS_BITS = DEF_BIAS_BITS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       setup,
   output logic       param_out,
   output logic       busy,
   output logic       done
);

   localparam int TOTAL_BITS = total_bits(NEURONS, INPUTS, BIAS_BITS);
   localparam int BIT_CNT_W  = $clog2(TOTAL_BITS + 1);

   localparam logic [BIT_CNT_W-1:0] REM_FULL = BIT_CNT_W'(TOTAL_BITS);
   localparam logic [BIT_CNT_W-1:0] REM_ONE  = BIT_CNT_W'(1);
   localparam logic [BIT_CNT_W-1:0] REM_TWO  = BIT_CNT_W'(2);

   state_t                 state;
   logic [BIT_CNT_W-1:0]   remaining;
   logic [3:0]             byte_bits;
   logic                   sr_empty;
   logic                   handshake;
   logic                   sr_load;
   logic                   sr_shift;

   assign handshake = in_valid && in_ready;
   assign sr_load   = handshake && !abort;
   assign sr_shift  = (state == SHIFT) && !sr_empty && !abort;

   bnn_piso8 u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (in_data),
      .msb   (param_out),
      .count (byte_bits),
      .empty (sr_empty)
   );

   // Outputs are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         in_ready  <= 1'b0;
         setup     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort && (state != IDLE)) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         setup    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= LOAD;
                  remaining <= REM_FULL;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            LOAD: begin
               if (handshake) begin
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  setup    <= 1'b1;
               end
            end
            SHIFT: begin
               if (remaining != '0) begin
                  remaining <= remaining - REM_ONE;
               end
               if (remaining <= REM_ONE) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  setup    <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else if (handshake) begin
                  in_ready <= 1'b0;
               end else if (byte_bits <= 4'd1) begin
                  state    <= LOAD;
                  in_ready <= 1'b1;
                  setup    <= 1'b0;
               end else begin
                  // Open the refill window for the last bit of this byte, unless it ends the load.
                  in_ready <= (byte_bits == 4'd2) && (remaining > REM_TWO);
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               setup    <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
